// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet: activity encodings, attribute limits and rates.
package tamagotchi_pkg;

    localparam int unsigned ATRIB_W = 8;
    localparam int unsigned TIMER_W = 16;

    // One-hot activity code shared with controlador_atributos.
    typedef enum logic [3:0] {
        OCIOSO     = 4'b0000,
        DORMINDO   = 4'b0001,
        COMENDO    = 4'b0010,
        DANDO_AULA = 4'b0100,
        MORTO      = 4'b1000
    } estado_t;

    localparam logic [ATRIB_W-1:0] MAX_FOME       = 8'd100;
    localparam logic [ATRIB_W-1:0] MAX_SONO       = 8'd100;
    localparam logic [ATRIB_W-1:0] MAX_FELICIDADE = 8'd100;
    localparam logic [ATRIB_W-1:0] VEL_SUBIDA     = 8'd5;
    localparam logic [ATRIB_W-1:0] VEL_DESCIDA    = 8'd1;

    // Clamp an attribute reading to the 0..100 range.
    function automatic logic [ATRIB_W-1:0] satura(input logic [ATRIB_W-1:0] valor,
                                                  input logic [ATRIB_W-1:0] maximo);
        return (valor > maximo) ? maximo : valor;
    endfunction

endpackage

// File: rtl/controlador_estados_if.sv
// Buttons, attribute levels and activity outputs of the pet state machine.
interface controlador_estados_if;
    import tamagotchi_pkg::*;

    logic                botao_comer;
    logic                botao_dormir;
    logic                botao_aula;
    logic [ATRIB_W-1:0]  fome;
    logic [ATRIB_W-1:0]  felicidade;
    logic [ATRIB_W-1:0]  sono;
    logic                morreu;
    estado_t             estado;
    logic                ocupado;
    logic                alerta;

    modport master (
        output botao_comer, botao_dormir, botao_aula,
        output fome, felicidade, sono, morreu,
        input  estado, ocupado, alerta
    );

    modport slave (
        input  botao_comer, botao_dormir, botao_aula,
        input  fome, felicidade, sono, morreu,
        output estado, ocupado, alerta
    );

endinterface

// File: rtl/controlador_estados_detector_borda.sv
// Rising-edge detector: registered history bit, combinational edge pulse.
module detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic sinal,
    output logic borda_c
);

    logic anterior_q;

    // Remember last sampled level; reset clears the history.
    always_ff @(posedge clk) begin
        if (rst) anterior_q <= 1'b0;
        else     anterior_q <= sinal;
    end

    assign borda_c = sinal & ~anterior_q;

endmodule

// File: rtl/controlador_estados.sv
// Pet activity state machine: button requests, timed activities, early exits,
// death absorption and low-attribute warning.
// Optional build macro AUTO_SONO_EN: automatic sleep when rest is low in OCIOSO.
module controlador_estados
    import tamagotchi_pkg::*;
#(
    parameter int unsigned        T_ATIVIDADE   = 2048,
    parameter logic [ATRIB_W-1:0] LIMIAR_ALERTA = 8'd20
) (
    input  logic                 clk,
    input  logic                 rst,
    controlador_estados_if.slave bus
);

    localparam logic [TIMER_W-1:0] CARGA_TIMER = TIMER_W'(T_ATIVIDADE - 1);

    logic borda_comer_c;
    logic borda_dormir_c;
    logic borda_aula_c;

    estado_t             estado_q;
    estado_t             estado_d;
    logic [TIMER_W-1:0]  timer_q;
    logic [TIMER_W-1:0]  timer_d;
    logic                ocupado_q;
    logic                ocupado_d;
    logic                alerta_q;
    logic                alerta_d;

    logic [ATRIB_W-1:0]  fome_c;
    logic [ATRIB_W-1:0]  felicidade_c;
    logic [ATRIB_W-1:0]  sono_c;
    logic                algum_baixo_c;
    logic                fim_atividade_c;

    detector_borda u_borda_comer (
        .clk     (clk),
        .rst     (rst),
        .sinal   (bus.botao_comer),
        .borda_c (borda_comer_c)
    );

    detector_borda u_borda_dormir (
        .clk     (clk),
        .rst     (rst),
        .sinal   (bus.botao_dormir),
        .borda_c (borda_dormir_c)
    );

    detector_borda u_borda_aula (
        .clk     (clk),
        .rst     (rst),
        .sinal   (bus.botao_aula),
        .borda_c (borda_aula_c)
    );

    assign fome_c        = satura(bus.fome, MAX_FOME);
    assign felicidade_c  = satura(bus.felicidade, MAX_FELICIDADE);
    assign sono_c        = satura(bus.sono, MAX_SONO);
    assign algum_baixo_c = (fome_c <= LIMIAR_ALERTA) || (felicidade_c <= LIMIAR_ALERTA)
                        || (sono_c <= LIMIAR_ALERTA);

    // Exit condition of the running activity: timeout, served attribute full, or tired class.
    always_comb begin
        fim_atividade_c = (timer_q == '0);
        case (estado_q)
            DORMINDO:   if (sono_c >= MAX_SONO) fim_atividade_c = 1'b1;
            COMENDO:    if (fome_c >= MAX_FOME) fim_atividade_c = 1'b1;
            DANDO_AULA: if ((felicidade_c >= MAX_FELICIDADE) || (sono_c <= LIMIAR_ALERTA))
                            fim_atividade_c = 1'b1;
            default:    fim_atividade_c = 1'b0;
        endcase
    end

    // Next state, timer and registered-output values; death overrides everything.
    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;

        case (estado_q)
            OCIOSO: begin
                if (borda_comer_c) begin
                    estado_d = COMENDO;
                    timer_d  = CARGA_TIMER;
                end else if (borda_dormir_c) begin
                    estado_d = DORMINDO;
                    timer_d  = CARGA_TIMER;
                end else if (borda_aula_c) begin
                    estado_d = DANDO_AULA;
                    timer_d  = CARGA_TIMER;
                end
`ifdef AUTO_SONO_EN
                else if (sono_c <= LIMIAR_ALERTA) begin
                    estado_d = DORMINDO;
                    timer_d  = CARGA_TIMER;
                end
`endif
            end
            DORMINDO, COMENDO, DANDO_AULA: begin
                if (fim_atividade_c) begin
                    estado_d = OCIOSO;
                    timer_d  = '0;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            MORTO: begin
                timer_d = '0;
            end
            default: begin
                estado_d = OCIOSO;
                timer_d  = '0;
            end
        endcase

        if (bus.morreu) begin
            estado_d = MORTO;
            timer_d  = '0;
        end

        ocupado_d = (estado_d == DORMINDO) || (estado_d == COMENDO) || (estado_d == DANDO_AULA);
        alerta_d  = algum_baixo_c && (estado_d != MORTO);
    end

    // State, timer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            timer_q   <= '0;
            ocupado_q <= 1'b0;
            alerta_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            timer_q   <= timer_d;
            ocupado_q <= ocupado_d;
            alerta_q  <= alerta_d;
        end
    end

    assign bus.estado  = estado_q;
    assign bus.ocupado = ocupado_q;
    assign bus.alerta  = alerta_q;

endmodule

// File: tb/tb_controlador_estados.sv
// Self-checking bench for controlador_estados with a behavioural activity model.
module tb_controlador_estados;

    localparam int unsigned T = 2048;
    localparam int unsigned LIM = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int failures = 0;

    controlador_estados_if bus ();

    controlador_estados #(
        .T_ATIVIDADE   (T),
        .LIMIAR_ALERTA (8'd20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: ativ 0=idle 1=sleep 2=eat 3=class 4=dead; restantes = cycles left in activity.
    int ativ = 0;
    int restantes = 0;
    bit pc = 0, pd = 0, pa = 0;
    bit alerta_m = 0;

    function automatic int lim100(input logic [7:0] v);
        return (int'(v) > 100) ? 100 : int'(v);
    endfunction

    function automatic logic [3:0] exp_estado();
        case (ativ)
            1:       return 4'b0001;
            2:       return 4'b0010;
            3:       return 4'b0100;
            4:       return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic exp_ocupado();
        return (ativ >= 1) && (ativ <= 3);
    endfunction

    function automatic void modelo_passo();
        bit ec, ed, ea, auto_ok;
        int f, h, s, servido;
        f = lim100(bus.fome);
        h = lim100(bus.felicidade);
        s = lim100(bus.sono);
        ec = bus.botao_comer & ~pc;
        ed = bus.botao_dormir & ~pd;
        ea = bus.botao_aula & ~pa;
`ifdef AUTO_SONO_EN
        auto_ok = 1'b1;
`else
        auto_ok = 1'b0;
`endif
        if (rst) begin
            ativ = 0; restantes = 0; pc = 0; pd = 0; pa = 0; alerta_m = 0;
        end else begin
            pc = bus.botao_comer; pd = bus.botao_dormir; pa = bus.botao_aula;
            if (bus.morreu) begin
                ativ = 4;
            end else if (ativ == 0) begin
                if (ec) ativ = 2;
                else if (ed) ativ = 1;
                else if (ea) ativ = 3;
                else if (auto_ok && s <= LIM) ativ = 1;
                if (ativ != 0) restantes = T;
            end else if (ativ != 4) begin
                servido = (ativ == 1) ? s : (ativ == 2) ? f : h;
                restantes--;
                if (restantes == 0 || servido >= 100 || (ativ == 3 && s <= LIM)) ativ = 0;
            end
            alerta_m = (ativ != 4) && (f <= LIM || h <= LIM || s <= LIM);
        end
    endfunction

    task automatic ciclo();
        @(posedge clk);
        modelo_passo();
        @(negedge clk);
    endtask

    task automatic zera_entradas();
        bus.botao_comer = 0; bus.botao_dormir = 0; bus.botao_aula = 0;
        bus.fome = 8'd50; bus.felicidade = 8'd50; bus.sono = 8'd50; bus.morreu = 0;
    endtask

    task automatic aplica_reset();
        rst = 1; ciclo(); rst = 0;
    endtask

    task automatic test_reset();
        zera_entradas();
        rst = 1; ciclo(); ciclo();
        checks++;
        if (bus.estado !== 4'b0000 || bus.ocupado !== 1'b0 || bus.alerta !== 1'b0) begin
            failures++;
            $display("FAIL reset_state estado=%b ocupado=%b alerta=%b required 0000/0/0",
                     bus.estado, bus.ocupado, bus.alerta);
        end
        rst = 0;
        for (int i = 0; i < 100; i++) begin
            ciclo();
            checks++;
            if (bus.estado !== 4'b0000 || bus.ocupado !== 1'b0 || bus.alerta !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset cycle=%0d estado=%b ocupado=%b alerta=%b required 0000/0/0",
                         i, bus.estado, bus.ocupado, bus.alerta);
            end
        end
    endtask

    task automatic test_comer();
        zera_entradas();
        bus.botao_comer = 1; ciclo(); bus.botao_comer = 0;
        checks++;
        if (bus.estado !== 4'b0010 || bus.ocupado !== 1'b1) begin
            failures++;
            $display("FAIL comer_entry estado=%b ocupado=%b required 0010/1", bus.estado, bus.ocupado);
        end
        for (int i = 1; i < T; i++) ciclo();
        checks++;
        if (bus.estado !== 4'b0010 || bus.estado !== exp_estado()) begin
            failures++;
            $display("FAIL comer_last_cycle estado=%b required 0010", bus.estado);
        end
        bus.botao_comer = 1;
        ciclo();
        checks++;
        if (bus.estado !== 4'b0000 || bus.ocupado !== 1'b0) begin
            failures++;
            $display("FAIL comer_timeout estado=%b ocupado=%b required 0000/0", bus.estado, bus.ocupado);
        end
        for (int i = 0; i < 20; i++) begin
            ciclo();
            checks++;
            if (bus.estado !== 4'b0000) begin
                failures++;
                $display("FAIL comer_held_no_reentry cycle=%0d estado=%b required 0000", i, bus.estado);
            end
        end
        bus.botao_comer = 0; ciclo();
    endtask

    task automatic test_prioridade();
        zera_entradas();
        bus.botao_comer = 1; bus.botao_aula = 1; ciclo();
        checks++;
        if (bus.estado !== 4'b0010) begin
            failures++;
            $display("FAIL prio_comer_over_aula estado=%b required 0010", bus.estado);
        end
        bus.botao_comer = 0; bus.botao_aula = 0; bus.fome = 8'd130; ciclo();
        checks++;
        if (bus.estado !== 4'b0000 || bus.estado !== exp_estado()) begin
            failures++;
            $display("FAIL comer_saturated_exit estado=%b required 0000", bus.estado);
        end
        bus.fome = 8'd50; bus.botao_aula = 1; ciclo(); bus.botao_aula = 0;
        checks++;
        if (bus.estado !== 4'b0100) begin
            failures++;
            $display("FAIL aula_entry estado=%b required 0100", bus.estado);
        end
        for (int i = 0; i < 5; i++) ciclo();
        bus.sono = 8'd20; ciclo();
        checks++;
        if (bus.estado !== 4'b0000 || bus.alerta !== 1'b1) begin
            failures++;
            $display("FAIL aula_low_sono_exit estado=%b alerta=%b required 0000/1", bus.estado, bus.alerta);
        end
        bus.sono = 8'd50; ciclo();
    endtask

    task automatic test_dormir_saturado();
        zera_entradas();
        bus.sono = 8'd95; bus.botao_dormir = 1; ciclo(); bus.botao_dormir = 0;
        for (int i = 1; i < 300; i++) ciclo();
        checks++;
        if (bus.estado !== 4'b0001 || bus.estado !== exp_estado()) begin
            failures++;
            $display("FAIL dormir_before_full estado=%b required 0001", bus.estado);
        end
        bus.sono = 8'd100; ciclo();
        checks++;
        if (bus.estado !== 4'b0000 || bus.ocupado !== 1'b0) begin
            failures++;
            $display("FAIL dormir_full_exit estado=%b ocupado=%b required 0000/0", bus.estado, bus.ocupado);
        end
        bus.sono = 8'd50; ciclo();
    endtask

    task automatic test_morte();
        zera_entradas();
        bus.botao_aula = 1; ciclo(); bus.botao_aula = 0; ciclo();
        bus.morreu = 1; ciclo(); bus.morreu = 0;
        checks++;
        if (bus.estado !== 4'b1000 || bus.ocupado !== 1'b0 || bus.alerta !== 1'b0) begin
            failures++;
            $display("FAIL morte_entry estado=%b ocupado=%b alerta=%b required 1000/0/0",
                     bus.estado, bus.ocupado, bus.alerta);
        end
        bus.sono = 8'd10;
        for (int i = 0; i < 12; i++) begin
            bus.botao_comer = i[0]; bus.botao_dormir = i[1]; bus.botao_aula = ~i[0];
            ciclo();
            checks++;
            if (bus.estado !== 4'b1000 || bus.alerta !== 1'b0) begin
                failures++;
                $display("FAIL morte_absorbing cycle=%0d estado=%b alerta=%b required 1000/0",
                         i, bus.estado, bus.alerta);
            end
        end
        zera_entradas();
        aplica_reset();
        checks++;
        if (bus.estado !== 4'b0000) begin
            failures++;
            $display("FAIL morte_reset estado=%b required 0000", bus.estado);
        end
        rst = 1; bus.morreu = 1; ciclo(); rst = 0; bus.morreu = 0;
        checks++;
        if (bus.estado !== 4'b0000) begin
            failures++;
            $display("FAIL reset_beats_morreu estado=%b required 0000", bus.estado);
        end
    endtask

    task automatic test_reset_historico();
        zera_entradas();
        bus.botao_dormir = 1; ciclo(); ciclo();
        rst = 1; ciclo(); rst = 0;
        checks++;
        if (bus.estado !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_activity estado=%b required 0000", bus.estado);
        end
        ciclo();
        checks++;
        if (bus.estado !== 4'b0001 || bus.estado !== exp_estado()) begin
            failures++;
            $display("FAIL held_through_reset estado=%b required 0001", bus.estado);
        end
        bus.botao_dormir = 0;
        aplica_reset();
    endtask

    task automatic test_sono_baixo();
        zera_entradas();
        bus.sono = 8'd15; ciclo();
`ifdef AUTO_SONO_EN
        checks++;
        if (bus.estado !== 4'b0001 || bus.alerta !== 1'b1) begin
            failures++;
            $display("FAIL auto_sono_entry estado=%b alerta=%b required 0001/1", bus.estado, bus.alerta);
        end
`else
        checks++;
        if (bus.estado !== 4'b0000 || bus.alerta !== 1'b1) begin
            failures++;
            $display("FAIL no_auto_sono estado=%b alerta=%b required 0000/1", bus.estado, bus.alerta);
        end
`endif
        zera_entradas();
        aplica_reset();
        bus.sono = 8'd15; bus.botao_aula = 1; ciclo();
        checks++;
        if (bus.estado !== 4'b0100) begin
            failures++;
            $display("FAIL aula_beats_auto_sono estado=%b required 0100", bus.estado);
        end
        ciclo();
        checks++;
        if (bus.estado !== 4'b0000) begin
            failures++;
            $display("FAIL aula_tired_exit estado=%b required 0000", bus.estado);
        end
        for (int i = 0; i < 4; i++) begin
            ciclo();
            checks++;
            if (bus.estado !== exp_estado() || bus.alerta !== alerta_m) begin
                failures++;
                $display("FAIL sono_baixo_model cycle=%0d estado=%b alerta=%b required %b/%b",
                         i, bus.estado, bus.alerta, exp_estado(), alerta_m);
            end
        end
        zera_entradas();
        aplica_reset();
    endtask

    task automatic test_aleatorio();
        zera_entradas();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.botao_comer  = ~bus.botao_comer;
            if ($urandom_range(0, 7) == 0) bus.botao_dormir = ~bus.botao_dormir;
            if ($urandom_range(0, 7) == 0) bus.botao_aula   = ~bus.botao_aula;
            if ($urandom_range(0, 30) == 0) bus.fome       = 8'($urandom_range(0, 130));
            if ($urandom_range(0, 30) == 0) bus.felicidade = 8'($urandom_range(0, 130));
            if ($urandom_range(0, 30) == 0) bus.sono       = 8'($urandom_range(0, 130));
            bus.morreu = ($urandom_range(0, 599) == 0);
            rst = ($urandom_range(0, 299) == 0);
            ciclo();
            checks++;
            if (bus.estado !== exp_estado() || bus.ocupado !== exp_ocupado() || bus.alerta !== alerta_m) begin
                failures++;
                $display("FAIL random cycle=%0d estado=%b ocupado=%b alerta=%b required %b/%b/%b",
                         i, bus.estado, bus.ocupado, bus.alerta, exp_estado(), exp_ocupado(), alerta_m);
            end
        end
        rst = 0;
    endtask

    initial begin
        zera_entradas();
        test_reset();
        test_comer();
        test_prioridade();
        test_dormir_saturado();
        test_morte();
        test_reset_historico();
        test_sono_baixo();
        test_aleatorio();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controlador_estados.md
# controlador_estados

Activity state machine of the pet: turns player button presses and the current attribute levels into the one-hot `estado` code that drives `controlador_atributos`. It closes the loop with that block by consuming `fome`, `felicidade`, `sono` and `morreu` and producing the activity code that block acts on. It also times each activity, ends it early when the served attribute saturates, and raises a low-attribute warning for the display.

## Interface
- `T_ATIVIDADE`, 2048: activity duration in clocks, equal to 8 attribute update periods; legal range 2..65535.
- `LIMIAR_ALERTA`, 8'd20: an attribute at or below this value is "low".
- `clk  in  1`: single system clock.
- `rst  in  1`: synchronous, active-high reset.
- `botao_comer  in  1`: debounced level, feed button.
- `botao_dormir  in  1`: debounced level, sleep button.
- `botao_aula  in  1`: debounced level, "give class" button.
- `fome  in  8`: hunger attribute, 0..100.
- `felicidade  in  8`: happiness attribute, 0..100.
- `sono  in  8`: rest attribute, 0..100.
- `morreu  in  1`: sticky death flag from the attribute controller.
- `estado  out  4`: one-hot activity code.
- `ocupado  out  1`: an activity is in progress.
- `alerta  out  1`: at least one attribute is low.

## Operation
- Encodings:
  - OCIOSO 4'b0000
  - DORMINDO 4'b0001
  - COMENDO 4'b0010
  - DANDO_AULA 4'b0100
  - MORTO 4'b1000
- Reset values: `estado`=OCIOSO, `ocupado`=0, `alerta`=0, timer=0, button history=0.
- Buttons are rising-edge detected internally. A held button produces exactly one request.
- OCIOSO:
  - On a button edge, go to the matching activity.
  - Priority on simultaneous edges: comer > dormir > aula.
  - On entry, the timer loads `T_ATIVIDADE-1`.
- Activity states:
  - The timer decrements by 1 each clock.
  - Button edges are ignored.
  - Return to OCIOSO when any of these holds:
    - timer==0
    - the served attribute is >=100 (`sono` for DORMINDO, `fome` for COMENDO, `felicidade` for DANDO_AULA)
    - DANDO_AULA only: `sono` <= `LIMIAR_ALERTA`.
- MORTO:
  - `morreu`=1 forces MORTO from any state on the next edge. This has the highest priority, above buttons and exits.
  - MORTO is absorbing; only `rst` leaves it.
  - Timer is held at 0.
- Attribute inputs above 100 are treated as 100. All comparisons are unsigned 8-bit.
- `ocupado` = 1 exactly when `estado` is DORMINDO, COMENDO or DANDO_AULA.
- `alerta`:
  - Registered: 1 when any attribute <= `LIMIAR_ALERTA` and next state is not MORTO.
  - Forced to 0 in MORTO.
- Timer width is 16 bits. The timer never wraps: decrement stops at 0.

## Timing
- All outputs are registered.
- Button edge latency: button low at edge k-1 and high at edge k gives new `estado` visible after edge k (1 cycle).
- Activity length with no early exit: exactly `T_ATIVIDADE` clocks in the activity state, then OCIOSO.
- Early exit: the attribute condition sampled at edge k gives OCIOSO after edge k.
- Exit plus button edge in the same cycle: exit wins and the edge is discarded. A new request needs a fresh edge once in OCIOSO.
- `rst` asserted mid-activity: OCIOSO after that edge, and button history is cleared. A button held through reset release therefore counts as an edge on the first cycle after reset.
- `morreu` and `rst` on the same edge: `rst` wins.

## Configuration
- `AUTO_SONO_EN`:
  - Defined: in OCIOSO with no button edge and `sono` <= `LIMIAR_ALERTA`, enter DORMINDO automatically, with the same timer load and exits as a button request.
  - Undefined: DORMINDO is entered only via `botao_dormir`.
  - A button edge in the same cycle takes precedence over auto-sleep.

## Structure
- Shared package `tamagotchi_pkg`:
  - state encodings (OCIOSO, DORMINDO, COMENDO, DANDO_AULA, MORTO)
  - MAX_FOME / MAX_SONO / MAX_FELICIDADE (100)
  - VEL_SUBIDA / VEL_DESCIDA
- `controlador_atributos` imports the same encodings.
- Sub-module `detector_borda`: 1-bit registered rising-edge detector with synchronous reset, instantiated once per button.

## Test plan
- Reset, then idle with all attributes at 50 → `estado`=0000, `ocupado`=0, `alerta`=0 for 100 cycles.
- `botao_comer` high 1 cycle with `fome`=50 → `estado`=0010 next cycle; OCIOSO after exactly 2048 cycles; holding the button afterwards does not re-enter.
- `botao_comer` and `botao_aula` rising on the same edge → COMENDO. DANDO_AULA with `sono` dropping to 20 → OCIOSO on the following cycle.
- In DORMINDO, `sono` steps 95→100 at cycle 300 → OCIOSO one cycle later, well before timer expiry.
- `morreu` pulse during DANDO_AULA → `estado`=1000 next cycle; stays there through button presses and `morreu` returning to 0, with `alerta`=0. `rst` → OCIOSO.
- With `AUTO_SONO_EN`: `sono`=15 in OCIOSO → DORMINDO next cycle; `botao_aula` edge in the same cycle → DANDO_AULA instead, which then exits next cycle on low `sono`. Without the macro, `sono`=15 leaves `estado` in OCIOSO and `alerta`=1.
